tlb_array: RTL and testbench

TLB_ARRAY -- requirements
Module: tlb_array

---
 rtl/tlb_array.sv | 183 ++++++++++++++++++
 tb/tb_tlb_array.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_array.sv
`default_nettype none
// ============================================================================
// Module      : tlb_array
// Description : Fully associative TLB storage. Each entry pairs an even and an
//               odd page. Combinational search with lowest-index priority,
//               combinational read port, synchronous write, and an optional
//               INVTLB-style invalidate enabled by macro TLB_INVTLB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_array #(
    parameter int TLBNUM = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    // search port
    input  logic [18:0]               s_vppn,
    input  logic                      s_va_bit12,
    input  logic [9:0]                s_asid,
    output logic                      s_found,
    output logic [$clog2(TLBNUM)-1:0] s_index,
    output logic [19:0]               s_ppn,
    output logic [5:0]                s_ps,
    output logic [1:0]                s_plv,
    output logic [1:0]                s_mat,
    output logic                      s_d,
    output logic                      s_v,
    // write port
    input  logic                      we,
    input  logic [$clog2(TLBNUM)-1:0] w_index,
    input  logic [36:0]               w_hi,
    input  logic [25:0]               w_lo0,
    input  logic [25:0]               w_lo1,
    // read port
    input  logic [$clog2(TLBNUM)-1:0] r_index,
    output logic [36:0]               r_hi,
    output logic [25:0]               r_lo0,
    output logic [25:0]               r_lo1,
    // invalidate request
    input  logic                      invtlb_valid,
    input  logic [4:0]                invtlb_op,
    input  logic [9:0]                invtlb_asid,
    input  logic [18:0]               invtlb_va
);

    localparam int IDXW = $clog2(TLBNUM);

    // Entry storage; lo words keep the packed {ppn, plv, mat, d, v} layout.
    logic [TLBNUM-1:0] e_q, e_d;
    logic [TLBNUM-1:0] g_q, g_d;
    logic [18:0]       vppn_q [TLBNUM];
    logic [18:0]       vppn_d [TLBNUM];
    logic [5:0]        ps_q   [TLBNUM];
    logic [5:0]        ps_d   [TLBNUM];
    logic [9:0]        asid_q [TLBNUM];
    logic [9:0]        asid_d [TLBNUM];
    logic [25:0]       lo0_q  [TLBNUM];
    logic [25:0]       lo0_d  [TLBNUM];
    logic [25:0]       lo1_q  [TLBNUM];
    logic [25:0]       lo1_d  [TLBNUM];

    logic [TLBNUM-1:0] s_match;
    logic              hit;
    logic [IDXW-1:0]   hit_idx;
    logic              odd_page;
    logic [25:0]       page;
    logic [TLBNUM-1:0] inv_sel;

    // 4 KB pages compare the full VPPN; 2 MB pages ignore the low 9 bits.
    // Any other page size never matches.
    function automatic logic va_hit(input logic [18:0] ent_vppn,
                                    input logic [5:0]  ent_ps,
                                    input logic [18:0] va);
        va_hit = ((ent_ps == 6'd12) && (ent_vppn == va)) ||
                 ((ent_ps == 6'd21) && (ent_vppn[18:9] == va[18:9]));
    endfunction

    // Per-entry search match.
    always_comb begin
        s_match = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            s_match[i] = e_q[i] && (g_q[i] || (asid_q[i] == s_asid)) &&
                         va_hit(vppn_q[i], ps_q[i], s_vppn);
        end
    end

    // Priority encoder: scanning downward lets the lowest index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (s_match[i]) begin
                hit     = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    // Odd/even page select and zeroed outputs on a miss.
    always_comb begin
        odd_page = (ps_q[hit_idx] == 6'd12) ? s_va_bit12 : s_vppn[8];
        page     = odd_page ? lo1_q[hit_idx] : lo0_q[hit_idx];
        s_found  = hit;
        s_index  = hit ? hit_idx : '0;
        s_ps     = hit ? ps_q[hit_idx] : 6'd0;
        {s_ppn, s_plv, s_mat, s_d, s_v} = hit ? page : 26'd0;
    end

    // Read port packs the addressed entry exactly like the write inputs.
    assign r_hi  = {e_q[r_index], vppn_q[r_index], ps_q[r_index],
                    asid_q[r_index], g_q[r_index]};
    assign r_lo0 = lo0_q[r_index];
    assign r_lo1 = lo1_q[r_index];

`ifdef TLB_INVTLB_EN
    // Invalidate selection by opcode; ops 7..31 select nothing.
    always_comb begin
        inv_sel = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (invtlb_op)
                5'd0, 5'd1: inv_sel[i] = 1'b1;
                5'd2:       inv_sel[i] = g_q[i];
                5'd3:       inv_sel[i] = !g_q[i];
                5'd4:       inv_sel[i] = !g_q[i] && (asid_q[i] == invtlb_asid);
                5'd5:       inv_sel[i] = !g_q[i] && (asid_q[i] == invtlb_asid) &&
                                         va_hit(vppn_q[i], ps_q[i], invtlb_va);
                5'd6:       inv_sel[i] = (g_q[i] || (asid_q[i] == invtlb_asid)) &&
                                         va_hit(vppn_q[i], ps_q[i], invtlb_va);
                default:    inv_sel[i] = 1'b0;
            endcase
        end
    end
`else
    // Invalidate disabled: ports are kept for interface compatibility only.
    logic unused_invtlb;
    assign inv_sel       = '0;
    assign unused_invtlb = ^{invtlb_valid, invtlb_op, invtlb_asid, invtlb_va};
`endif

    // Next state: invalidate clears e first, then a write overrides its entry.
    always_comb begin
        e_d    = e_q;
        g_d    = g_q;
        vppn_d = vppn_q;
        ps_d   = ps_q;
        asid_d = asid_q;
        lo0_d  = lo0_q;
        lo1_d  = lo1_q;
        if (invtlb_valid) begin
            e_d = e_q & ~inv_sel;
        end
        if (we) begin
            {e_d[w_index], vppn_d[w_index], ps_d[w_index],
             asid_d[w_index], g_d[w_index]} = w_hi;
            lo0_d[w_index] = w_lo0;
            lo1_d[w_index] = w_lo1;
        end
    end

    // Entry registers with synchronous reset overriding write and invalidate.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            g_q <= '0;
            for (int i = 0; i < TLBNUM; i++) begin
                vppn_q[i] <= '0;
                ps_q[i]   <= '0;
                asid_q[i] <= '0;
                lo0_q[i]  <= '0;
                lo1_q[i]  <= '0;
            end
        end else begin
            e_q    <= e_d;
            g_q    <= g_d;
            vppn_q <= vppn_d;
            ps_q   <= ps_d;
            asid_q <= asid_d;
            lo0_q  <= lo0_d;
            lo1_q  <= lo1_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlb_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_array
// Description : Directed self-checking bench for tlb_array. Expected values are
//               queued when stimulus is applied and compared when sampled.
//               Invalidate expectations follow macro TLB_INVTLB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_array;

`ifdef TLB_INVTLB_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [18:0] s_vppn;
    logic        s_va_bit12;
    logic [9:0]  s_asid;
    logic        s_found;
    logic [3:0]  s_index;
    logic [19:0] s_ppn;
    logic [5:0]  s_ps;
    logic [1:0]  s_plv;
    logic [1:0]  s_mat;
    logic        s_d;
    logic        s_v;
    logic        we;
    logic [3:0]  w_index;
    logic [36:0] w_hi;
    logic [25:0] w_lo0;
    logic [25:0] w_lo1;
    logic [3:0]  r_index;
    logic [36:0] r_hi;
    logic [25:0] r_lo0;
    logic [25:0] r_lo1;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;
    logic [9:0]  invtlb_asid;
    logic [18:0] invtlb_va;

    tlb_array #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset),
        .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
        .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
        .we(we), .w_index(w_index), .w_hi(w_hi), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .r_index(r_index), .r_hi(r_hi), .r_lo0(r_lo0), .r_lo1(r_lo1),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0: search outputs, 1: r_hi
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] sv(input logic f, input logic [3:0] idx,
                                       input logic [19:0] ppn, input logic [5:0] ps,
                                       input logic [1:0] plv, input logic [1:0] mat,
                                       input logic d, input logic v);
        sv = {27'd0, f, idx, ppn, ps, plv, mat, d, v};
    endfunction

    function automatic logic [36:0] mkhi(input logic e, input logic [18:0] vppn,
                                         input logic [5:0] ps, input logic [9:0] asid,
                                         input logic g);
        mkhi = {e, vppn, ps, asid, g};
    endfunction

    function automatic logic [25:0] mklo(input logic [19:0] ppn, input logic [1:0] plv,
                                         input logic [1:0] mat, input logic d,
                                         input logic v);
        mklo = {ppn, plv, mat, d, v};
    endfunction

    // Pop one expectation and compare it with the sampled DUT outputs.
    task automatic check();
        exp_t        e;
        logic [63:0] obs;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            if (e.kind == 0)
                obs = {27'd0, s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v};
            else
                obs = {27'd0, r_hi};
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // All tasks start and end one time unit after a rising edge.
    task automatic search(input string tag, input logic [18:0] vppn, input logic b12,
                          input logic [9:0] asid, input logic [63:0] expv);
        exp_t e;
        s_vppn = vppn; s_va_bit12 = b12; s_asid = asid;
        e.tag = tag; e.kind = 0; e.val = expv;
        sb.push_back(e);
        @(negedge clk);
        check();
        @(posedge clk); #1;
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [36:0] exph);
        exp_t e;
        r_index = idx;
        e.tag = tag; e.kind = 1; e.val = {27'd0, exph};
        sb.push_back(e);
        @(negedge clk);
        check();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [36:0] hi,
                      input logic [25:0] lo0, input logic [25:0] lo1);
        we = 1'b1; w_index = idx; w_hi = hi; w_lo0 = lo0; w_lo1 = lo1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] va);
        invtlb_valid = 1'b1; invtlb_op = op; invtlb_asid = asid; invtlb_va = va;
        @(posedge clk); #1;
        invtlb_valid = 1'b0;
    endtask

    logic [36:0] hi3, hi7, hi2, hi0, hi1, hi5;
    logic [25:0] lo3a, lo3b, lo7a, lo7b, lo2a, lo2b;

    initial begin
        reset = 1'b1; we = 1'b0; w_index = '0; w_hi = '0; w_lo0 = '0; w_lo1 = '0;
        r_index = '0; s_vppn = '0; s_va_bit12 = 1'b0; s_asid = '0;
        invtlb_valid = 1'b0; invtlb_op = '0; invtlb_asid = '0; invtlb_va = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state: no hits, read port all zero.
        search("reset_search", 19'h12345, 1'b1, 10'd5, sv(0, 0, 0, 0, 0, 0, 0, 0));
        rd("reset_read0", 4'd0, 37'd0);

        // 4 KB entry at idx 3; same-cycle search must still miss.
        hi3  = mkhi(1, 19'h12345, 6'd12, 10'd5, 0);
        lo3a = mklo(20'h11111, 2'd1, 2'd1, 1, 1);
        lo3b = mklo(20'hABCDE, 2'd3, 2'd2, 0, 1);
        we = 1'b1; w_index = 4'd3; w_hi = hi3; w_lo0 = lo3a; w_lo1 = lo3b;
        search("same_cycle_old", 19'h12345, 1'b1, 10'd5, sv(0, 0, 0, 0, 0, 0, 0, 0));
        we = 1'b0;
        search("ps12_odd", 19'h12345, 1'b1, 10'd5, sv(1, 3, 20'hABCDE, 12, 3, 2, 0, 1));
        search("ps12_even", 19'h12345, 1'b0, 10'd5, sv(1, 3, 20'h11111, 12, 1, 1, 1, 1));
        search("asid_miss", 19'h12345, 1'b1, 10'd6, sv(0, 0, 0, 0, 0, 0, 0, 0));

        // 2 MB global entry at idx 7.
        hi7  = mkhi(1, 19'h40000, 6'd21, 10'd0, 1);
        lo7a = mklo(20'h22222, 2'd0, 2'd0, 0, 1);
        lo7b = mklo(20'h33333, 2'd1, 2'd3, 1, 1);
        wr(4'd7, hi7, lo7a, lo7b);
        search("ps21_odd", 19'h401FF, 1'b0, 10'd9, sv(1, 7, 20'h33333, 21, 1, 3, 1, 1));
        search("ps21_even", 19'h400FF, 1'b1, 10'd9, sv(1, 7, 20'h22222, 21, 0, 0, 0, 1));

        // Duplicate entries: lowest index wins.
        hi2  = mkhi(1, 19'h0ABCD, 6'd12, 10'd1, 0);
        lo2a = mklo(20'h44444, 2'd2, 2'd1, 1, 1);
        lo2b = mklo(20'h55555, 2'd0, 2'd3, 0, 0);
        wr(4'd9, hi2, lo2a, lo2b);
        wr(4'd2, hi2, lo2a, lo2b);
        search("multi_hit_low", 19'h0ABCD, 1'b0, 10'd1, sv(1, 2, 20'h44444, 12, 2, 1, 1, 1));
        rd("read_idx9", 4'd9, hi2);

        // Invalidate by ASID (op 4) and global (op 2).
        hi0 = mkhi(1, 19'h00100, 6'd12, 10'd0, 1);
        hi1 = mkhi(1, 19'h00200, 6'd12, 10'd4, 0);
        wr(4'd0, hi0, 26'd1, 26'd1);
        wr(4'd1, hi1, 26'd1, 26'd1);
        inv(5'd4, 10'd4, 19'd0);
        rd("op4_idx1", 4'd1, mkhi(!INV, 19'h00200, 6'd12, 10'd4, 0));
        rd("op4_idx0", 4'd0, hi0);
        inv(5'd2, 10'd0, 19'd0);
        rd("op2_idx0", 4'd0, mkhi(!INV, 19'h00100, 6'd12, 10'd0, 1));
        inv(5'd9, 10'd5, 19'h12345);
        rd("op9_noeffect", 4'd3, hi3);

        // Write and op 0 in the same cycle: only the written entry survives.
        hi5 = mkhi(1, 19'h05555, 6'd12, 10'd7, 0);
        we = 1'b1; w_index = 4'd5; w_hi = hi5; w_lo0 = 26'd3; w_lo1 = 26'd3;
        inv(5'd0, 10'd0, 19'd0);
        we = 1'b0;
        rd("wr_inv_idx5", 4'd5, hi5);
        rd("wr_inv_idx2", 4'd2, mkhi(!INV, 19'h0ABCD, 6'd12, 10'd1, 0));
        search("wr_inv_idx3", 19'h12345, 1'b1, 10'd5,
               INV ? sv(0, 0, 0, 0, 0, 0, 0, 0) : sv(1, 3, 20'hABCDE, 12, 3, 2, 0, 1));

        // Fill every entry, then reset with a competing write.
        for (int i = 0; i < 16; i++)
            wr(4'(i), mkhi(1, 19'(i), 6'd12, 10'(i), 0), 26'(i + 1), 26'(i + 2));
        rd("fill_idx10", 4'd10, mkhi(1, 19'd10, 6'd12, 10'd10, 0));
        reset = 1'b1;
        we = 1'b1; w_index = 4'd0; w_hi = hi5; w_lo0 = 26'd7; w_lo1 = 26'd7;
        @(posedge clk); #1;
        reset = 1'b0; we = 1'b0;
        for (int i = 0; i < 16; i++)
            rd($sformatf("post_reset_hi%0d", i), 4'(i), 37'd0);
        search("post_reset_search", 19'd3, 1'b0, 10'd3, sv(0, 0, 0, 0, 0, 0, 0, 0));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
